serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; SHALL be at least 1.
REQ-002 Parameter STEP, default 1, bits added per clock; SHALL be at least 1 and SHALL divide WIDTH exactly (elaboration error otherwise).
REQ-003 clk  input  1  the only clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  operands and mode present.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-008 b  input  WIDTH  operand B, unsigned or two's complement.
REQ-009 cin  input  1  carry-in for add, borrow-in for subtract.
REQ-010 sub  input  1  0 = add, 1 = subtract.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 sum  output  WIDTH  result bits.
REQ-014 cout  output  1  carry out of the MSB; for subtract, 1 = no borrow.
REQ-015 ovf  output  1  two's-complement overflow.

Function
REQ-016 FSM states SHALL be IDLE, RUN and DONE; all outputs SHALL be registered or decoded from state only.
REQ-017 In IDLE: in_ready=1 and out_valid=0; an accept occurs on an edge with in_valid=1.
REQ-018 On accept the block SHALL capture a, (sub ? ~b : b) and initial carry (cin XOR sub), clear the step counter, and enter RUN.
REQ-019 Resulting arithmetic:
- add: sum = a + b + cin
- subtract: sum = a - b - cin
- both: modulo 2^WIDTH
REQ-020 Each RUN cycle SHALL add the next STEP bits, LSB-first, using per-bit full-adder logic (sum = x^y^c, carry = majority). The carry SHALL be held in a flop between steps.
REQ-021 RUN SHALL last exactly N = WIDTH/STEP cycles, then enter DONE; out_valid SHALL rise N cycles after the accept edge.
REQ-022 In DONE:
- out_valid=1 and in_ready=0.
- sum, cout and ovf SHALL hold stable until the edge with out_ready=1.
- That edge SHALL return the FSM to IDLE.
REQ-023 ovf SHALL equal (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
REQ-024 in_ready SHALL be 0 throughout RUN and DONE; in_valid and operand changes in those states SHALL be ignored.
REQ-025 Minimum spacing between accepts SHALL be N+2 cycles (with out_ready held 1).
REQ-026 sum, cout and ovf SHALL retain the last result from DONE until the next accept; their values during RUN are undefined to the consumer.
REQ-027 The step counter SHALL be ceil(log2(N+1)) bits wide and SHALL not wrap within an operation.

Reset
REQ-028 An edge with rst_n=0 SHALL force:
- state IDLE, in_ready=1 on the following cycle
- out_valid=0, sum=0, cout=0, ovf=0
- carry and step counter cleared
REQ-029 Reset in RUN or DONE SHALL discard the operation; no out_valid SHALL follow for it.
REQ-030 in_valid asserted during reset SHALL not be accepted.

Verification
REQ-031 WIDTH=8, STEP=1: a=0x0F, b=0x01, cin=0, sub=0 -> out_valid exactly 8 cycles after accept; sum=0x10, cout=0, ovf=0.
REQ-032 WIDTH=8, STEP=1: a=0xFF, b=0x01, cin=0, sub=0 -> sum=0x00, cout=1, ovf=0; a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
REQ-033 WIDTH=8, STEP=1, subtract: a=0x05, b=0x07, sub=1:
- cin=0 -> sum=0xFE, cout=0, ovf=0
- cin=1 -> sum=0xFD
REQ-034 WIDTH=8, STEP=4: a=0xA5, b=0x5B, cin=1, sub=0 -> out_valid 2 cycles after accept; sum=0x01, cout=1, ovf=0.
REQ-035 Backpressure: out_ready=0 for 5 cycles in DONE, with new in_valid pulses -> out_valid, sum and cout stable; in_ready=0; no new accept. Raising out_ready -> IDLE next cycle; the next accept yields its correct sum.
REQ-036 Reset mid-operation: rst_n=0 for 1 cycle at RUN step 3 -> out_valid stays 0 and in_ready=1 after reset. A fresh operation then completes with the correct result and latency.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder/subtractor with valid/ready handshakes.
// Adds STEP bits per clock, LSB first, over WIDTH/STEP RUN cycles. The carry
// is kept in a flop between steps. Results stay on sum/cout/ovf until the
// next operation is accepted.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  if (WIDTH < 1 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_param_check
    $error("serial_adder: WIDTH must be >= 1 and an exact multiple of STEP >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // One full-adder bit: returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    full_add = {(x & y) | (x & c) | (y & c), x ^ y ^ c};
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [STEP:0]    chain_s;
  logic [STEP-1:0]  slice_s;

  // Ripple carry through the STEP low bits of the operand shift registers.
  always_comb begin
    chain_s    = '0;
    slice_s    = '0;
    chain_s[0] = carry_q;
    for (int i = 0; i < STEP; i++) begin
      {chain_s[i+1], slice_s[i]} = full_add(a_q[i], b_q[i], chain_s[i]);
    end
  end

  // Next-state logic: accept in IDLE, one slice per RUN cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = cin ^ sub;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> STEP;
        b_d     = b_q >> STEP;
        carry_d = chain_s[STEP];
        // New result bits enter at the top; after N steps sum_q is aligned.
        sum_d   = WIDTH'({slice_s, sum_q} >> STEP);
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = DONE;
          cout_d  = chain_s[STEP];
          ovf_d   = chain_s[STEP] ^ chain_s[STEP-1];
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for two serial_adder instances
// (WIDTH=8 with STEP=1 and STEP=4) driven with hand-computed vectors.
module tb_serial_adder;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       iv1 = 1'b0, ir1, ov1, or1 = 1'b1, cin1 = 1'b0, sub1 = 1'b0, co1, of1;
  logic [7:0] a1 = 8'h00, b1 = 8'h00, s1;
  logic       iv4 = 1'b0, ir4, ov4, or4 = 1'b1, cin4 = 1'b0, sub4 = 1'b0, co4, of4;
  logic [7:0] a4 = 8'h00, b4 = 8'h00, s4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t q1[$];
  exp_t q4[$];

  serial_adder #(.WIDTH(8), .STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .cin(cin1), .sub(sub1), .out_valid(ov1), .out_ready(or1), .sum(s1),
    .cout(co1), .ovf(of1)
  );

  serial_adder #(.WIDTH(8), .STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .cin(cin4), .sub(sub4), .out_valid(ov4), .out_ready(or4), .sum(s4),
    .cout(co4), .ovf(of4)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Issue one operation to dut1 and push its expected result.
  task automatic send1(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s,
                       input logic [7:0] esum, input logic ecout, input logic eovf);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (!ir1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ir1) chk("dut1_ready_timeout", 32'd0, 32'd1);
    a1 = a; b1 = b; cin1 = c; sub1 = s; iv1 = 1'b1;
    @(posedge clk);
    #1;
    iv1 = 1'b0;
    e.sum = esum; e.cout = ecout; e.ovf = eovf; e.acc = cyc;
    q1.push_back(e);
  endtask

  // Issue one operation to dut4 and push its expected result.
  task automatic send4(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s,
                       input logic [7:0] esum, input logic ecout, input logic eovf);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (!ir4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ir4) chk("dut4_ready_timeout", 32'd0, 32'd1);
    a4 = a; b4 = b; cin4 = c; sub4 = s; iv4 = 1'b1;
    @(posedge clk);
    #1;
    iv4 = 1'b0;
    e.sum = esum; e.cout = ecout; e.ovf = eovf; e.acc = cyc;
    q4.push_back(e);
  endtask

  task automatic drain;
    int n = 0;
    while ((q1.size() != 0 || q4.size() != 0 || ov1 || ov4) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  // Monitor for dut1: pop on rising out_valid, then check stability while held.
  initial begin
    logic prev = 1'b0;
    exp_t cur;
    logic have = 1'b0;
    forever begin
      @(negedge clk);
      if (ov1) begin
        if (!prev) begin
          if (q1.size() == 0) begin
            chk("dut1_unexpected_out_valid", 32'd1, 32'd0);
            have = 1'b0;
          end else begin
            cur  = q1.pop_front();
            have = 1'b1;
            chk("dut1_sum", {24'd0, s1}, {24'd0, cur.sum});
            chk("dut1_cout", {31'd0, co1}, {31'd0, cur.cout});
            chk("dut1_ovf", {31'd0, of1}, {31'd0, cur.ovf});
            chk("dut1_latency", cyc - cur.acc, 32'd8);
          end
        end else if (have) begin
          chk("dut1_hold_sum", {24'd0, s1}, {24'd0, cur.sum});
          chk("dut1_hold_cout", {31'd0, co1}, {31'd0, cur.cout});
        end
        chk("dut1_in_ready_in_done", {31'd0, ir1}, 32'd0);
      end
      prev = ov1;
    end
  end

  // Monitor for dut4.
  initial begin
    logic prev = 1'b0;
    exp_t cur;
    forever begin
      @(negedge clk);
      if (ov4 && !prev) begin
        if (q4.size() == 0) begin
          chk("dut4_unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          cur = q4.pop_front();
          chk("dut4_sum", {24'd0, s4}, {24'd0, cur.sum});
          chk("dut4_cout", {31'd0, co4}, {31'd0, cur.cout});
          chk("dut4_ovf", {31'd0, of4}, {31'd0, cur.ovf});
          chk("dut4_latency", cyc - cur.acc, 32'd2);
        end
      end
      prev = ov4;
    end
  end

  initial begin
    // Reset with in_valid asserted: must not be accepted.
    a1 = 8'h33; b1 = 8'h44; iv1 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    iv1 = 1'b0;
    rst_n = 1'b1;
    chk("rst_in_ready1", {31'd0, ir1}, 32'd1);
    chk("rst_out_valid1", {31'd0, ov1}, 32'd0);
    chk("rst_sum1", {24'd0, s1}, 32'd0);
    chk("rst_cout1", {31'd0, co1}, 32'd0);
    chk("rst_ovf1", {31'd0, of1}, 32'd0);
    chk("rst_in_ready4", {31'd0, ir4}, 32'd1);
    chk("rst_sum4", {24'd0, s4}, 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_no_accept", {31'd0, ir1}, 32'd1);

    // STEP=1 directed vectors.
    send1(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
    send1(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    send1(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    send1(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    send1(8'h05, 8'h07, 1'b1, 1'b1, 8'hFD, 1'b0, 1'b0);
    send1(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    send1(8'h03, 8'h03, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    send1(8'h64, 8'h64, 1'b0, 1'b0, 8'hC8, 1'b0, 1'b1);
    send1(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);

    // STEP=4 directed vectors.
    send4(8'hA5, 8'h5B, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
    send4(8'h70, 8'h10, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    send4(8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    drain();

    // Backpressure: hold out_ready low in DONE while poking in_valid.
    or1 = 1'b0;
    send1(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);
    begin
      int n = 0;
      while (!ov1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("bp_reached_done", {31'd0, ov1}, 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      a1 = 8'(i * 17); b1 = 8'hC3; iv1 = (i % 2 == 0);
      @(negedge clk);
      chk("bp_out_valid_held", {31'd0, ov1}, 32'd1);
    end
    iv1 = 1'b0;
    or1 = 1'b1;
    @(negedge clk);
    chk("bp_idle_after_release", {31'd0, ir1}, 32'd1);
    chk("bp_out_valid_dropped", {31'd0, ov1}, 32'd0);
    send1(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);
    drain();

    // Reset on the third RUN edge discards the operation.
    @(negedge clk);
    a1 = 8'h11; b1 = 8'h22; cin1 = 1'b0; sub1 = 1'b0; iv1 = 1'b1;
    @(posedge clk);
    #1;
    iv1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_in_ready", {31'd0, ir1}, 32'd1);
    chk("midrst_out_valid", {31'd0, ov1}, 32'd0);
    chk("midrst_sum", {24'd0, s1}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("midrst_no_out_valid", {31'd0, ov1}, 32'd0);
    end
    send1(8'h20, 8'h0A, 1'b1, 1'b0, 8'h2B, 1'b0, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule
